mem_access_unit: RTL and testbench

Load/store front-end that sits directly upstream of the byte-addressed data RAM, which has a G-bit address, a 32-bit big-endian word port, a combinational read and a full-word write on the falling clock edge. It accepts one byte, halfword or word request at a time from the core over a valid/ready handshake. Sub-word stores are turned into read-modify-write sequences so that bytes outside the access are preserved. Loads are returned sign- or zero-extended over a valid/ready response channel.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store front-end for a big-endian byte-addressed RAM.
// Sub-word stores use read-modify-write; define MAU_ALIGN_CHECK_EN to reject misaligned accesses.
module mem_access_unit #(
    parameter int unsigned G = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [G-1:0] req_addr,
    input  logic [31:0]  req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [31:0]  resp_rdata,
    output logic         resp_err,
    output logic [G-1:0] ram_addr,
    output logic [31:0]  ram_wdata,
    output logic         ram_en,
    input  logic [31:0]  ram_rdata
);
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 24;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t         state, state_nxt;
    logic           we_q;
    logic [1:0]     size_q;
    logic           signed_q;
    logic [G-1:0]   addr_q;
    logic [DW-1:0]  wdata_q;
    logic [KW-1:0]  word_q;
    logic [DW-1:0]  rdata_q;
    logic           err_q;
    logic           misaligned_c;
    logic           bad_req_c;

`ifdef MAU_ALIGN_CHECK_EN
    assign misaligned_c = ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned_c = 1'b0;
`endif
    assign bad_req_c = (req_size == SZ_RSVD) || misaligned_c;

    // Leftmost byte/halfword of the big-endian word, extended to 32 bits.
    function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] w,
                                                  input logic [1:0] sz,
                                                  input logic sgn);
        logic [DW-1:0] r;
        case (sz)
            2'b00:   r = {{24{sgn & w[31]}}, w[31:24]};
            2'b01:   r = {{16{sgn & w[31]}}, w[31:16]};
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_en     = 1'b0;
        ram_wdata  = '0;
        ram_addr   = addr_q;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad_req_c)                          state_nxt = RESP;
                    else if (req_we && req_size == SZ_WORD) state_nxt = WRITE;
                    else                                    state_nxt = READ;
                end
            end
            READ:  state_nxt = we_q ? WRITE : RESP;
            WRITE: begin
                ram_en = 1'b1;
                case (size_q)
                    SZ_WORD: ram_wdata = wdata_q;
                    SZ_HALF: ram_wdata = {wdata_q[15:0], word_q[15:0]};
                    default: ram_wdata = {wdata_q[7:0], word_q[23:0]};
                endcase
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset forces every output quiet in the same cycle, suppressing any pending write.
        if (RST) begin
            state_nxt  = IDLE;
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            ram_en     = 1'b0;
            ram_wdata  = '0;
            ram_addr   = '0;
            resp_rdata = '0;
            resp_err   = 1'b0;
        end
    end

    // Request latch, RMW capture and response registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= bad_req_c;
                    end
                end
                READ: begin
                    word_q <= ram_rdata[KW-1:0];
                    if (!we_q) rdata_q <= load_extend(ram_rdata, size_q, signed_q);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level reference memory predicts every response,
// a negedge monitor checks responses, latency and handshake behaviour against it.
module tb_mem_access_unit;
    localparam int G   = 10;
    localparam int MSZ = 1 << G;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [1:0]   req_size = 2'b00;
    logic         req_signed = 1'b0;
    logic [G-1:0] req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [31:0]  resp_rdata;
    logic         resp_err;
    logic [G-1:0] ram_addr;
    logic [31:0]  ram_wdata;
    logic         ram_en;
    logic [31:0]  ram_rdata;

    logic [7:0] ram     [MSZ];
    logic [7:0] ref_mem [MSZ];
    exp_t       sb[$];
    int checks = 0, errors = 0, cyc = 0, wr_seen = 0, wr_exp = 0, rr_mode = 0;
    bit in_resp = 0, hs_prev = 0;

    mem_access_unit #(.G(G)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en),
        .ram_rdata(ram_rdata)
    );

    initial forever #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    function automatic logic [G-1:0] aoff(input logic [G-1:0] a, input int i);
        return a + G'(i);
    endfunction

    // RAM: combinational big-endian read, full-word write on the falling edge.
    assign ram_rdata = {ram[ram_addr], ram[aoff(ram_addr, 1)],
                        ram[aoff(ram_addr, 2)], ram[aoff(ram_addr, 3)]};
    always @(negedge CLK) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++) ram[aoff(ram_addr, i)] = ram_wdata[8*(3-i) +: 8];
        end
    end

    always @(posedge CLK) begin
        #1;
        case (rr_mode)
            1:       resp_ready = 1'b0;
            2:       resp_ready = 1'b1;
            default: resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: the access touches only its own 1/2/4 bytes, with address wrap.
    task automatic predict(input logic we, input logic [1:0] sz, input logic sgn,
                           input logic [G-1:0] a, input logic [31:0] wd, output exp_t e);
        int n;
        logic [31:0] v;
        bit bad;
        bad = (sz == 2'b11);
`ifdef MAU_ALIGN_CHECK_EN
        if (sz == 2'b01 && a[0]) bad = 1;
        if (sz == 2'b10 && a[1:0] != 2'b00) bad = 1;
`endif
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e.rdata = '0;
        e.err   = bad;
        e.acc   = 0;
        if (bad) begin
            e.lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[aoff(a, i)] = wd[8*(n-1-i) +: 8];
            e.lat = (n == 4) ? 2 : 3;
            wr_exp++;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[aoff(a, i)]);
            if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            e.rdata = v;
            e.lat   = 2;
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [G-1:0] a, input logic [31:0] wd,
                         input bit track, input bit use_c, input logic [31:0] cval);
        exp_t e;
        bit got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(posedge CLK); #1;
            if (req_ready) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: req_ready=0, want 1 (cycle %0d)", cyc);
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        if (track) begin
            predict(we, sz, sgn, a, wd, e);
            if (use_c) e.rdata = cval;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = G'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge CLK);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare each presented response with the scoreboard head.
    always @(negedge CLK) begin
        exp_t e;
        if (ram_en) wr_seen++;
        if (hs_prev && !RST) chk("ready_after_resp", 32'(req_ready), 32'd1);
        hs_prev = 0;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                e = sb[0];
                if (!in_resp) begin
                    chk("resp_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
                    in_resp = 1;
                end
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                chk("ram_en_in_resp", 32'(ram_en), 32'd0);
                if (resp_ready) begin
                    void'(sb.pop_front());
                    in_resp = 0;
                    hs_prev = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int mism;
        logic [1:0] sz;
        logic [G-1:0] a;
        int r;
        for (int i = 0; i < MSZ; i++) begin
            b = 8'($urandom);
            ram[i] = b;
            ref_mem[i] = b;
        end

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        issue(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 1, 0, 0);
        issue(0, 2'b00, 1, 10'h010, 0, 1, 1, 32'hFFFFFFDE);
        issue(0, 2'b00, 0, 10'h013, 0, 1, 1, 32'h000000EF);

        issue(1, 2'b10, 0, 10'h020, 32'h11223344, 1, 0, 0);
        issue(1, 2'b00, 0, 10'h021, 32'h000000AA, 1, 0, 0);
        issue(0, 2'b10, 0, 10'h020, 0, 1, 1, 32'h11AA3344);

        issue(1, 2'b10, 0, 10'h040, 32'hFFFFFFFF, 1, 0, 0);
        issue(1, 2'b01, 0, 10'h040, 32'h00008001, 1, 0, 0);
        issue(0, 2'b01, 1, 10'h040, 0, 1, 1, 32'hFFFF8001);
        issue(0, 2'b10, 0, 10'h040, 0, 1, 1, 32'h8001FFFF);

        // Consumer stalls a load response; the response must hold.
        drain();
        rr_mode = 1;
        issue(0, 2'b10, 0, 10'h020, 0, 1, 1, 32'h11AA3344);
        repeat (8) @(negedge CLK);
        chk("hold_resp_valid", 32'(resp_valid), 32'd1);
        rr_mode = 2;
        drain();
        rr_mode = 0;

        // Reset during the WRITE cycle of a word store discards it.
        issue(1, 2'b10, 0, 10'h008, 32'hCAFEF00D, 1, 0, 0);
        drain();
        issue(1, 2'b10, 0, 10'h008, 32'h12345678, 0, 0, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_ram_en", 32'(ram_en), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_ram_wdata", ram_wdata, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_midrst", 32'(req_ready), 32'd1);
        issue(0, 2'b10, 0, 10'h008, 0, 1, 1, 32'hCAFEF00D);

        issue(1, 2'b11, 0, 10'h050, 32'h55555555, 1, 0, 0);
        issue(0, 2'b11, 1, 10'h051, 0, 1, 0, 0);

`ifdef MAU_ALIGN_CHECK_EN
        issue(1, 2'b10, 0, 10'h102, 32'h0BADF00D, 1, 0, 0);
        issue(0, 2'b10, 0, 10'h100, 0, 1, 0, 0);
        issue(0, 2'b01, 1, 10'h041, 0, 1, 0, 0);
`else
        issue(1, 2'b10, 0, 10'h3FE, 32'hA1B2C3D4, 1, 0, 0);
        issue(0, 2'b00, 0, 10'h3FE, 0, 1, 1, 32'h000000A1);
        issue(0, 2'b00, 0, 10'h3FF, 0, 1, 1, 32'h000000B2);
        issue(0, 2'b00, 0, 10'h000, 0, 1, 1, 32'h000000C3);
        issue(0, 2'b00, 0, 10'h001, 0, 1, 1, 32'h000000D4);
        issue(0, 2'b10, 0, 10'h3FE, 0, 1, 1, 32'hA1B2C3D4);
`endif

        for (int k = 0; k < 400; k++) begin
            r  = $urandom_range(0, 15);
            sz = (r == 0) ? 2'b11 : 2'(r % 3);
            case ($urandom_range(0, 3))
                0:       a = G'($urandom);
                1:       a = G'(10'h3FC + 10'($urandom_range(0, 3)));
                default: a = G'($urandom_range(0, 31));
            endcase
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1, 0, 0);
        end

        drain();
        repeat (3) @(posedge CLK);
        mism = 0;
        for (int i = 0; i < MSZ; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("ram_contents_mismatched_bytes", 32'(mism), 32'd0);
        chk("ram_write_cycles", 32'(wr_seen), 32'(wr_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
